tap_controller: RTL and testbench
=================================

Name: tap_controller

Overview:
IEEE 1149.1 TAP controller that sequences the JTAG instruction path. It runs the 16-state TAP FSM from TMS, owns the instruction shift and update registers, and presents the updated instruction to the instruction decoder. It also produces capture, shift and update strobes for the data registers, and drives the registered, enabled TDO. It sits between the chip's JTAG pins and the decoder/data-register chains.

Parameters:
IR_WIDTH, 6, instruction register width in bits; the decoder uses one-hot encodings of this width.
IR_RESET, 6'b001000, value loaded into ir_out on reset and in Test-Logic-Reset (IDCODE).
IR_CAPTURE, 6'b000001, value loaded into the IR shift stage in Capture-IR; bits [1:0] must be 2'b01.

Ports:
tck  input  1  JTAG test clock; all logic is clocked by tck (posedge and negedge)
trst_n  input  1  asynchronous active-low TAP reset
tms  input  1  test mode select, sampled on posedge tck
tdi  input  1  test data in, sampled on posedge tck
dr_tdo  input  1  serial out of the data register currently selected by the decoder
tdo  output  1  test data out, changes on negedge tck
tdo_en  output  1  output enable for the TDO pad
ir_out  output  IR_WIDTH  current instruction, to the instruction decoder
tap_state  output  4  current FSM state encoding (debug/BSDL visibility)
capture_dr  output  1  high while state is Capture-DR
shift_dr  output  1  high while state is Shift-DR
update_dr  output  1  high while state is Update-DR
test_logic_reset  output  1  high while state is Test-Logic-Reset

Behaviour:
- State encodings: TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SH_DR=2, EX1_DR=1, PAU_DR=3, EX2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=E, SH_IR=A, EX1_IR=9, PAU_IR=B, EX2_IR=8, UPD_IR=D.
- The state register updates on posedge tck. The next state follows the 1149.1 diagram:
  - TLR: tms=0 -> RTI
  - RTI, UPD_DR, UPD_IR: tms=1 -> SEL_DR, else RTI
  - SEL_DR: 1 -> SEL_IR, 0 -> CAP_DR
  - SEL_IR: 1 -> TLR, 0 -> CAP_IR
  - CAP_x and SH_x: 1 -> EX1_x, 0 -> SH_x
  - EX1_x: 1 -> UPD_x, 0 -> PAU_x
  - PAU_x: 1 -> EX2_x, else hold
  - EX2_x: 1 -> UPD_x, 0 -> SH_x
- Five consecutive tms=1 posedges reach TLR from any state.
- Strobes (capture_dr, shift_dr, update_dr, test_logic_reset) are combinational decodes of the state register and carry no extra latency. A data register acts on the posedge while its strobe is high.
- IR shift stage (IR_WIDTH bits), acting on posedge:
  - CAP_IR: load IR_CAPTURE.
  - SH_IR: shift right, tdi enters the MSB, and bit 0 is the serial out.
  - All other states: hold its value, including Pause and Exit states.
- ir_out:
  - Loaded from the shift stage on the negedge of tck while in UPD_IR.
  - Set to IR_RESET on the negedge while in TLR.
  - Holds its value otherwise.
- TDO, updated on negedge tck:
  - SH_IR: tdo = shift stage bit 0, tdo_en=1.
  - SH_DR: tdo = dr_tdo, tdo_en=1.
  - All other states: tdo=0, tdo_en=0.
- Reset: trst_n low asynchronously forces state=TLR, IR shift stage=IR_CAPTURE, ir_out=IR_RESET, tdo=0, tdo_en=0, regardless of tck. The first posedge after release evaluates from TLR. Reset asserted mid-shift discards the partial IR with no update.
- tms is evaluated on the same posedge that shifts tdi, so the last bit of a shift is entered with tms=1 (the Shift->Exit1 edge still shifts).
- Pause states are unbounded; no timeout.

Test Plan:
- Async reset: hold trst_n=0 mid Shift-IR with no tck edge -> tap_state=F, ir_out=6'b001000, tdo_en=0 immediately; after release with tms=0 -> RTI (C) on the first posedge.
- Sync reset: from SH_DR (2), drive tms=1 for 5 posedges -> tap_state=F, test_logic_reset=1, ir_out=6'b001000 after the following negedge.
- IR load EXTEST:
  - From RTI, tms=1,1,0,0 -> SH_IR (A).
  - Shift tdi LSB-first 0,0,1,0,0,0 with tms=1 on the 6th bit; tdo emits 1,0,0,0,0,0 (IR_CAPTURE).
  - Then tms=1,0 -> ir_out=6'b000100 after the UPD_IR negedge, state RTI.
- DR shift: from RTI, tms=1,0,0 then 8x tms=0, then tms=1 -> capture_dr high for 1 cycle and shift_dr high for 9 cycles; tdo equals dr_tdo delayed by a half-cycle, and tdo_en=1 only during SH_DR.
- Pause-IR: shift 3 IR bits, go to PAU_IR (B) for 10 cycles, return via EX2_IR to SH_IR, shift 3 more -> ir_out equals all 6 bits in order; tdo_en=0 throughout the pause.
- Walk all 32 (state, tms) pairs -> each next-state matches the diagram above; no illegal encoding is ever reached.

Source files
------------

// File: rtl/tap_controller_if.sv
// JTAG pin and decoder-side signal bundle for the TAP controller.
// The master side drives the pins; the slave side is the controller itself.
interface tap_controller_if #(
  parameter int IR_WIDTH = 6
);
  logic                tms;
  logic                tdi;
  logic                dr_tdo;
  logic                tdo;
  logic                tdo_en;
  logic [IR_WIDTH-1:0] ir_out;
  logic [3:0]          tap_state;
  logic                capture_dr;
  logic                shift_dr;
  logic                update_dr;
  logic                test_logic_reset;

  modport master (
    output tms, tdi, dr_tdo,
    input  tdo, tdo_en, ir_out, tap_state,
    input  capture_dr, shift_dr, update_dr, test_logic_reset
  );

  modport slave (
    input  tms, tdi, dr_tdo,
    output tdo, tdo_en, ir_out, tap_state,
    output capture_dr, shift_dr, update_dr, test_logic_reset
  );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction shift/update registers,
// data-register strobes and the negedge-registered TDO driver.
module tap_controller #(
  parameter int                  IR_WIDTH   = 6,
  parameter logic [IR_WIDTH-1:0] IR_RESET   = 6'b001000,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 6'b000001
) (
  input  logic             tck,
  input  logic             trst_n,
  tap_controller_if.slave  jtag
);

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  tap_state_e          state_q, state_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TLR:                    state_d = jtag.tms ? TLR    : RTI;
      RTI, UPD_DR, UPD_IR:    state_d = jtag.tms ? SEL_DR : RTI;
      SEL_DR:                 state_d = jtag.tms ? SEL_IR : CAP_DR;
      SEL_IR:                 state_d = jtag.tms ? TLR    : CAP_IR;
      CAP_DR, SH_DR:          state_d = jtag.tms ? EX1_DR : SH_DR;
      EX1_DR:                 state_d = jtag.tms ? UPD_DR : PAU_DR;
      PAU_DR:                 state_d = jtag.tms ? EX2_DR : PAU_DR;
      EX2_DR:                 state_d = jtag.tms ? UPD_DR : SH_DR;
      CAP_IR, SH_IR:          state_d = jtag.tms ? EX1_IR : SH_IR;
      EX1_IR:                 state_d = jtag.tms ? UPD_IR : PAU_IR;
      PAU_IR:                 state_d = jtag.tms ? EX2_IR : PAU_IR;
      EX2_IR:                 state_d = jtag.tms ? UPD_IR : SH_IR;
      default:                state_d = TLR;
    endcase
  end

  // The Shift->Exit1 edge still shifts: the shift depends only on the current state.
  always_comb begin
    ir_shift_d = ir_shift_q;
    if (state_q == CAP_IR) begin
      ir_shift_d = IR_CAPTURE;
    end else if (state_q == SH_IR) begin
      ir_shift_d = {jtag.tdi, ir_shift_q[IR_WIDTH-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q    <= TLR;
      ir_shift_q <= IR_CAPTURE;
    end else begin
      state_q    <= state_d;
      ir_shift_q <= ir_shift_d;
    end
  end

  // Negedge stage: the instruction and TDO settle half a cycle after the state moves,
  // so the decoder and the pad see stable values across the next posedge.
  always_comb begin
    ir_out_d = ir_out_q;
    if (state_q == TLR) begin
      ir_out_d = IR_RESET;
    end else if (state_q == UPD_IR) begin
      ir_out_d = ir_shift_q;
    end
  end

  always_comb begin
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state_q == SH_IR) begin
      tdo_d    = ir_shift_q[0];
      tdo_en_d = 1'b1;
    end else if (state_q == SH_DR) begin
      tdo_d    = jtag.dr_tdo;
      tdo_en_d = 1'b1;
    end
  end

  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_out_q <= IR_RESET;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      ir_out_q <= ir_out_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign jtag.tdo              = tdo_q;
  assign jtag.tdo_en           = tdo_en_q;
  assign jtag.ir_out           = ir_out_q;
  assign jtag.tap_state        = state_q;
  assign jtag.capture_dr       = (state_q == CAP_DR);
  assign jtag.shift_dr         = (state_q == SH_DR);
  assign jtag.update_dr        = (state_q == UPD_DR);
  assign jtag.test_logic_reset = (state_q == TLR);

endmodule

// File: tb/tb_tap_controller.sv
// Self-checking bench for tap_controller: directed vector table, hand-written
// multi-cycle sequences and a randomized walk against a path/column TAP model.
module tb_tap_controller;
  localparam int             W      = 6;
  localparam logic [W-1:0]   IR_RST = 6'b001000;
  localparam logic [W-1:0]   IR_CAP = 6'b000001;

  logic tck    = 1'b0;
  logic trst_n = 1'b0;

  tap_controller_if #(.IR_WIDTH(W)) jif();

  tap_controller #(
    .IR_WIDTH  (W),
    .IR_RESET  (IR_RST),
    .IR_CAPTURE(IR_CAP)
  ) dut (
    .tck   (tck),
    .trst_n(trst_n),
    .jtag  (jif.slave)
  );

  always #5 tck = ~tck;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a position along the generic 1149.1 column plus a DR/IR column flag.
  typedef enum int {P_TLR, P_RTI, P_SEL, P_CAP, P_SH, P_EX1, P_PAU, P_EX2, P_UPD} pos_e;

  pos_e         m_pos;
  bit           m_ir;
  logic [W-1:0] m_sh;
  logic [W-1:0] m_irout;
  bit           m_tdo;
  bit           m_en;
  bit           cov [32];

  function automatic logic [3:0] enc(input pos_e p, input bit ir);
    case (p)
      P_TLR: return 4'hF;
      P_RTI: return 4'hC;
      P_SEL: return ir ? 4'h4 : 4'h7;
      P_CAP: return ir ? 4'hE : 4'h6;
      P_SH:  return ir ? 4'hA : 4'h2;
      P_EX1: return ir ? 4'h9 : 4'h1;
      P_PAU: return ir ? 4'hB : 4'h3;
      P_EX2: return ir ? 4'h8 : 4'h0;
      default: return ir ? 4'hD : 4'h5;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = P_TLR; m_ir = 1'b0; m_sh = IR_CAP; m_irout = IR_RST; m_tdo = 1'b0; m_en = 1'b0;
  endtask

  task automatic model_posedge(input bit t, input bit d);
    if (m_ir && m_pos == P_CAP) m_sh = IR_CAP;
    else if (m_ir && m_pos == P_SH) m_sh = (m_sh >> 1) | (W'(d) << (W - 1));
    case (m_pos)
      P_TLR:        m_pos = t ? P_TLR : P_RTI;
      P_RTI, P_UPD: begin m_pos = t ? P_SEL : P_RTI; m_ir = 1'b0; end
      P_SEL: begin
        if (!t)        m_pos = P_CAP;
        else if (m_ir) m_pos = P_TLR;
        else           m_ir  = 1'b1;
      end
      P_CAP, P_SH:  m_pos = t ? P_EX1 : P_SH;
      P_EX1:        m_pos = t ? P_UPD : P_PAU;
      P_PAU:        m_pos = t ? P_EX2 : P_PAU;
      default:      m_pos = t ? P_UPD : P_SH;
    endcase
    if (m_pos == P_TLR || m_pos == P_RTI) m_ir = 1'b0;
  endtask

  task automatic model_negedge(input bit dr);
    if (m_pos == P_TLR) m_irout = IR_RST;
    else if (m_pos == P_UPD && m_ir) m_irout = m_sh;
    m_en  = (m_pos == P_SH);
    m_tdo = (m_pos == P_SH) ? (m_ir ? m_sh[0] : dr) : 1'b0;
  endtask

  function automatic logic [31:0] dut_word();
    return {16'h0, jif.tap_state, jif.ir_out, jif.tdo, jif.tdo_en,
            jif.capture_dr, jif.shift_dr, jif.update_dr, jif.test_logic_reset};
  endfunction

  function automatic logic [31:0] model_word();
    bit not_ir = !m_ir;
    return {16'h0, enc(m_pos, m_ir), m_irout, m_tdo, m_en,
            (m_pos == P_CAP) && not_ir, (m_pos == P_SH) && not_ir,
            (m_pos == P_UPD) && not_ir, m_pos == P_TLR};
  endfunction

  // One TCK cycle: drive, posedge, negedge, then compare just after the negedge.
  task automatic tick(input bit t, input bit d, input bit dr);
    jif.tms = t; jif.tdi = d; jif.dr_tdo = dr;
    cov[{enc(m_pos, m_ir), t}] = 1'b1;
    @(posedge tck);
    model_posedge(t, d);
    @(negedge tck);
    model_negedge(dr);
    #1;
    check("outputs", dut_word(), model_word());
  endtask

  typedef struct {
    bit         tms;
    bit         tdi;
    logic [3:0] st;
    logic [5:0] ir;
    bit         tdo;
    bit         en;
  } vec_t;

  vec_t tbl [13];
  int   n_cap, n_shd;
  logic [W-1:0] bits;
  int   n_cov;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // EXTEST load from reset: RTI, SEL_DR, SEL_IR, CAP_IR, SH_IR, shift 0,0,1,0,0,0, UPD_IR, RTI.
    tbl[0]  = '{0, 0, 4'hC, 6'b001000, 0, 0};
    tbl[1]  = '{1, 0, 4'h7, 6'b001000, 0, 0};
    tbl[2]  = '{1, 0, 4'h4, 6'b001000, 0, 0};
    tbl[3]  = '{0, 0, 4'hE, 6'b001000, 0, 0};
    tbl[4]  = '{0, 0, 4'hA, 6'b001000, 1, 1};
    tbl[5]  = '{0, 0, 4'hA, 6'b001000, 0, 1};
    tbl[6]  = '{0, 0, 4'hA, 6'b001000, 0, 1};
    tbl[7]  = '{0, 1, 4'hA, 6'b001000, 0, 1};
    tbl[8]  = '{0, 0, 4'hA, 6'b001000, 0, 1};
    tbl[9]  = '{0, 0, 4'hA, 6'b001000, 0, 1};
    tbl[10] = '{1, 0, 4'h9, 6'b001000, 0, 0};
    tbl[11] = '{1, 0, 4'hD, 6'b000100, 0, 0};
    tbl[12] = '{0, 0, 4'hC, 6'b000100, 0, 0};

    jif.tms = 1'b1; jif.tdi = 1'b0; jif.dr_tdo = 1'b0;
    model_reset();
    #12;
    check("reset", dut_word(), model_word());
    #1 trst_n = 1'b1;

    foreach (tbl[i]) begin
      tick(tbl[i].tms, tbl[i].tdi, 1'b0);
      check($sformatf("tbl%0d", i), {26'h0, jif.tap_state, jif.ir_out, jif.tdo, jif.tdo_en},
            {26'h0, tbl[i].st, tbl[i].ir, tbl[i].tdo, tbl[i].en});
    end

    // DR scan: one capture cycle, nine shift cycles, random dr_tdo.
    n_cap = 0; n_shd = 0;
    tick(1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 1'($urandom));
      n_cap += int'(jif.capture_dr); n_shd += int'(jif.shift_dr);
    end
    tick(1, 0, 1'($urandom));
    n_cap += int'(jif.capture_dr); n_shd += int'(jif.shift_dr);
    check("dr_capture_cnt", n_cap, 1);
    check("dr_shift_cnt", n_shd, 9);
    tick(1, 0, 0);
    tick(0, 0, 0);

    // Pause-IR: three bits, ten pause cycles, three more bits.
    bits = W'($urandom);
    tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    tick(0, bits[0], 0); tick(0, bits[1], 0); tick(1, bits[2], 0);
    tick(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 1'($urandom), 1'b1);
      check("pause_tdo_en", {31'h0, jif.tdo_en}, 32'h0);
    end
    tick(1, 0, 0); tick(0, 0, 0);
    tick(0, bits[3], 0); tick(0, bits[4], 0); tick(1, bits[5], 0);
    tick(1, 0, 0);
    check("pause_ir_out", {26'h0, jif.ir_out}, {26'h0, bits});
    tick(0, 0, 0);

    // Synchronous reset from Shift-DR via five tms=1 edges.
    tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    check("sh_dr_reached", {28'h0, jif.tap_state}, 32'h2);
    for (int i = 0; i < 5; i++) tick(1, 0, 0);
    check("sync_rst", {25'h0, jif.tap_state, jif.test_logic_reset, jif.ir_out},
          {25'h0, 4'hF, 1'b1, IR_RST});

    // Asynchronous reset mid Shift-IR, between clock edges.
    tick(0, 0, 0); tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    tick(0, 1, 0); tick(0, 1, 0);
    trst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst", {20'h0, jif.tap_state, jif.ir_out, jif.tdo, jif.tdo_en},
          {20'h0, 4'hF, IR_RST, 1'b0, 1'b0});
    #1 trst_n = 1'b1;
    tick(0, 0, 0);
    check("post_rst_rti", {28'h0, jif.tap_state}, 32'hC);

    // Random walk: covers every (state, tms) pair against the model.
    for (int i = 0; i < 4000; i++) tick(1'($urandom), 1'($urandom), 1'($urandom));
    n_cov = 0;
    foreach (cov[i]) n_cov += int'(cov[i]);
    check("pair_coverage", n_cov, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
